pattern_sequencer: RTL and testbench

PATTERN_SEQUENCER -- requirements
Module: pattern_sequencer

---
 rtl/dance_pkg.sv | 46 ++++
 rtl/pattern_lfsr.sv | 27 ++
 rtl/pattern_sequencer.sv | 143 ++++++++++++++
 tb/tb_pattern_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dance_pkg.sv
// Shared definitions for the dance-game pattern path.
//   - Arrow one-hot constants, encoded as {up, down, left, right}.
//   - Sequencer state enum.
//   - Timing-window constants shared with score_tracker.
//   - next_arrow(): decodes two random bits to an arrow. If the result equals
//     the previous arrow it is rotated left one bit, so consecutive arrows differ.
package dance_pkg;

    localparam logic [3:0] ARROW_UP    = 4'b1000;
    localparam logic [3:0] ARROW_DOWN  = 4'b0100;
    localparam logic [3:0] ARROW_LEFT  = 4'b0010;
    localparam logic [3:0] ARROW_RIGHT = 4'b0001;
    localparam logic [3:0] ARROW_NONE  = 4'b0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } seq_state_t;

    // Hit windows in clock cycles, measured against pattern_timer.
    localparam logic [19:0] HIT_WINDOW_PERFECT = 20'd100_000;
    localparam logic [19:0] HIT_WINDOW_GOOD    = 20'd250_000;
    localparam logic [19:0] HIT_WINDOW_LATE    = 20'd450_000;

    function automatic logic [3:0] arrow_decode(input logic [1:0] sel);
        logic [3:0] arrow;
        case (sel)
            2'b00:   arrow = ARROW_RIGHT;
            2'b01:   arrow = ARROW_LEFT;
            2'b10:   arrow = ARROW_DOWN;
            default: arrow = ARROW_UP;
        endcase
        return arrow;
    endfunction

    function automatic logic [3:0] next_arrow(input logic [1:0] sel, input logic [3:0] prev);
        logic [3:0] arrow;
        arrow = arrow_decode(sel);
        if (arrow == prev)
            arrow = {arrow[2:0], arrow[3]};
        return arrow;
    endfunction

endpackage

// File: rtl/pattern_lfsr.sv
// 16-bit Fibonacci LFSR with taps 16, 14, 13 and 11.
// Ports:
//   clock  - system clock
//   reset  - async active-high; loads SEED
//   enable - advance one step this cycle
//   state  - current LFSR contents
module pattern_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    output logic [15:0] state
);

    logic feedback;

    assign feedback = state[15] ^ state[13] ^ state[12] ^ state[10];

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= SEED;
        else if (enable)
            state <= {state[14:0], feedback};
    end

endmodule

// File: rtl/pattern_sequencer.sv
// Arrow pattern sequencer for the dance game.
//
// Each round presents NUM_PATTERNS patterns. Each pattern is shown for
// SHOW_CYCLES cycles and is followed by GAP_CYCLES blank cycles. The arrows
// come from a free-running LFSR. That LFSR survives across rounds and is
// reseeded only by reset.
//
// Optional build macro:
//   MIRROR_PATTERN_EN - player B receives the same arrow as player A.
//
// Ports:
//   clock         - 50 MHz system clock
//   reset         - async active-high reset
//   game_active   - round enable level; when low the block returns to IDLE
//   pattern_a     - player A arrow, one-hot {up,down,left,right}
//   pattern_b     - player B arrow, same encoding
//   pattern_valid - high while a pattern is presented
//   pattern_timer - cycles since the current pattern appeared
//   pattern_count - patterns issued this round
//   round_done    - high once all patterns of the round have completed
//
// state | meaning
// IDLE  | waiting for game_active
// SHOW  | pattern presented, pattern_timer counting up
// GAP   | blank interval, gap_left counting down
// DONE  | round complete, waiting for game_active to drop
module pattern_sequencer
    import dance_pkg::*;
#(
    parameter logic [19:0] SHOW_CYCLES  = 20'd600_000,
    parameter logic [19:0] GAP_CYCLES   = 20'd250_000,
    parameter logic [7:0]  NUM_PATTERNS = 8'd32,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        game_active,
    output logic [3:0]  pattern_a,
    output logic [3:0]  pattern_b,
    output logic        pattern_valid,
    output logic [19:0] pattern_timer,
    output logic [7:0]  pattern_count,
    output logic        round_done
);

    seq_state_t  state;
    logic [15:0] lfsr_state;
    logic [19:0] gap_left;
    logic [3:0]  prev_a;
    logic [3:0]  prev_b;
    logic [3:0]  new_a;
    logic [3:0]  new_b;
    logic        start_show;
    logic        lfsr_unused;

    pattern_lfsr #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clock (clock),
        .reset (reset),
        .enable(1'b1),
        .state (lfsr_state)
    );

    assign new_a = next_arrow(lfsr_state[1:0], prev_a);
`ifdef MIRROR_PATTERN_EN
    assign new_b       = new_a;
    assign lfsr_unused = ^{lfsr_state[15:2], prev_b};
`else
    assign new_b       = next_arrow(lfsr_state[9:8], prev_b);
    assign lfsr_unused = ^{lfsr_state[15:10], lfsr_state[7:2]};
`endif

    // A new pattern starts from IDLE, or at the end of a gap while the round
    // still has patterns left to issue.
    assign start_show = game_active &&
                        ((state == IDLE) ||
                         (state == GAP && gap_left == 20'd0 && pattern_count != NUM_PATTERNS));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            pattern_a     <= ARROW_NONE;
            pattern_b     <= ARROW_NONE;
            pattern_valid <= 1'b0;
            pattern_timer <= 20'd0;
            pattern_count <= 8'd0;
            round_done    <= 1'b0;
            gap_left      <= 20'd0;
            prev_a        <= ARROW_NONE;
            prev_b        <= ARROW_NONE;
        end else if (!game_active) begin
            state         <= IDLE;
            pattern_a     <= ARROW_NONE;
            pattern_b     <= ARROW_NONE;
            pattern_valid <= 1'b0;
            pattern_timer <= 20'd0;
            pattern_count <= 8'd0;
            round_done    <= 1'b0;
            gap_left      <= 20'd0;
            prev_a        <= ARROW_NONE;
            prev_b        <= ARROW_NONE;
        end else if (start_show) begin
            state         <= SHOW;
            pattern_a     <= new_a;
            pattern_b     <= new_b;
            prev_a        <= new_a;
            prev_b        <= new_b;
            pattern_valid <= 1'b1;
            pattern_timer <= 20'd0;
            pattern_count <= pattern_count + 8'd1;
            round_done    <= 1'b0;
        end else begin
            case (state)
                SHOW: begin
                    if (pattern_timer == SHOW_CYCLES - 20'd1) begin
                        state         <= GAP;
                        pattern_a     <= ARROW_NONE;
                        pattern_b     <= ARROW_NONE;
                        pattern_valid <= 1'b0;
                        pattern_timer <= 20'd0;
                        gap_left      <= GAP_CYCLES - 20'd1;
                    end else begin
                        pattern_timer <= pattern_timer + 20'd1;
                    end
                end
                GAP: begin
                    // Reaching zero here means the round has issued all of
                    // its patterns. Any other gap end is taken by start_show.
                    if (gap_left == 20'd0) begin
                        state      <= DONE;
                        round_done <= 1'b1;
                    end else begin
                        gap_left <= gap_left - 20'd1;
                    end
                end
                DONE:    round_done <= 1'b1;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_sequencer.sv
module tb_pattern_sequencer;

    localparam int S    = 8;
    localparam int G    = 4;
    localparam int N    = 3;
    localparam int P    = S + G;
    localparam int KMAX = N * P + 1;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        game_active = 1'b0;
    logic [3:0]  pattern_a, pattern_b;
    logic        pattern_valid;
    logic [19:0] pattern_timer;
    logic [7:0]  pattern_count;
    logic        round_done;

    logic        ga_long = 1'b0;
    logic [3:0]  la, lb;
    logic        lvalid;
    logic [19:0] ltimer;
    logic [7:0]  lcount;
    logic        ldone;

    int checks = 0;
    int errors = 0;

    always #10 clock = ~clock;

    pattern_sequencer #(
        .SHOW_CYCLES(20'd8), .GAP_CYCLES(20'd4), .NUM_PATTERNS(8'd3), .LFSR_SEED(SEED)
    ) dut (
        .clock(clock), .reset(reset), .game_active(game_active),
        .pattern_a(pattern_a), .pattern_b(pattern_b), .pattern_valid(pattern_valid),
        .pattern_timer(pattern_timer), .pattern_count(pattern_count), .round_done(round_done)
    );

    pattern_sequencer #(
        .SHOW_CYCLES(20'd8), .GAP_CYCLES(20'd4), .NUM_PATTERNS(8'd255), .LFSR_SEED(SEED)
    ) dut_long (
        .clock(clock), .reset(reset), .game_active(ga_long),
        .pattern_a(la), .pattern_b(lb), .pattern_valid(lvalid),
        .pattern_timer(ltimer), .pattern_count(lcount), .round_done(ldone)
    );

    // Reference model. k counts the cycles since the round began. Every
    // scalar output follows from k by division: each pattern takes P cycles
    // and occupies one slot of the round.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic logic [3:0] pick(input logic [1:0] sel, input logic [3:0] prev);
        logic [3:0] a;
        a = 4'd1 << sel;
        if (a == prev) a = (a == 4'b1000) ? 4'b0001 : (a << 1);
        return a;
    endfunction

    logic [15:0] m_lfsr = SEED;
    logic [15:0] lf_before;
    int          k = 0;
    logic [3:0]  exp_a = 4'd0, exp_b = 4'd0, prev_a = 4'd0, prev_b = 4'd0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_lfsr = SEED; k = 0;
            exp_a = 0; exp_b = 0; prev_a = 0; prev_b = 0;
        end else begin
            lf_before = m_lfsr;
            m_lfsr    = lfsr_next(m_lfsr);
            if (!game_active) begin
                k = 0; exp_a = 0; exp_b = 0; prev_a = 0; prev_b = 0;
            end else begin
                if (k < KMAX) k = k + 1;
                if ((k - 1) / P >= N) begin
                    exp_a = 0; exp_b = 0;
                end else if ((k - 1) % P == 0) begin
                    exp_a = pick(lf_before[1:0], prev_a);
`ifdef MIRROR_PATTERN_EN
                    exp_b = exp_a;
`else
                    exp_b = pick(lf_before[9:8], prev_b);
`endif
                    prev_a = exp_a; prev_b = exp_b;
                end else if ((k - 1) % P == S) begin
                    exp_a = 0; exp_b = 0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    logic       last_valid = 1'b0;
    logic [3:0] last_a = 4'd0, last_b = 4'd0;

    task automatic check_all();
        int e_valid, e_timer, e_count, e_done, pp, ph;
        e_valid = 0; e_timer = 0; e_count = 0; e_done = 0;
        if (k > 0) begin
            pp = (k - 1) / P; ph = (k - 1) % P;
            if (pp >= N) begin
                e_done = 1; e_count = N;
            end else begin
                e_valid = (ph < S) ? 1 : 0;
                e_timer = (ph < S) ? ph : 0;
                e_count = pp + 1;
            end
        end
        chk("valid", {31'd0, pattern_valid}, e_valid);
        chk("timer", {12'd0, pattern_timer}, e_timer);
        chk("count", {24'd0, pattern_count}, e_count);
        chk("round_done", {31'd0, round_done}, e_done);
        chk("pattern_a", {28'd0, pattern_a}, {28'd0, exp_a});
        chk("pattern_b", {28'd0, pattern_b}, {28'd0, exp_b});
        chk("lfsr", {16'd0, dut.lfsr_state}, {16'd0, m_lfsr});
`ifdef MIRROR_PATTERN_EN
        chk("mirror_b_eq_a", {28'd0, pattern_b}, {28'd0, pattern_a});
`endif
        if (pattern_valid && !last_valid) begin
            chk("a_onehot", {31'd0, $onehot(pattern_a)}, 1);
            chk("b_onehot", {31'd0, $onehot(pattern_b)}, 1);
            if (e_count > 1) begin
                chk("a_differs", {31'd0, pattern_a != last_a}, 1);
`ifndef MIRROR_PATTERN_EN
                chk("b_differs", {31'd0, pattern_b != last_b}, 1);
`endif
            end
            last_a = pattern_a; last_b = pattern_b;
        end
        last_valid = pattern_valid;
    endtask

    task automatic cycle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            check_all();
        end
    endtask

    int         npat = 0;
    int         in_round = 0;
    logic       last_lvalid = 1'b0;
    logic       last_ldone = 1'b0;
    logic [3:0] prev_la = 4'd0, prev_lb = 4'd0;

    initial begin
        // Reset state
        cycle(2);
        reset = 1'b0;
        cycle(2);

        // Full round: timing, count sequence and round_done hold
        game_active = 1'b1;
        cycle(N * P);
        chk("done_not_early", {31'd0, round_done}, 0);
        cycle(1);
        chk("done_at_36", {31'd0, round_done}, 1);
        cycle(5);
        game_active = 1'b0;
        cycle(1);
        chk("done_cleared", {31'd0, round_done}, 0);
        cycle(1);

        // Drop game_active at timer=5 of pattern 2, then restart
        game_active = 1'b1;
        cycle(P + 6);
        chk("timer_at_drop", {12'd0, pattern_timer}, 5);
        chk("count_at_drop", {24'd0, pattern_count}, 2);
        game_active = 1'b0;
        cycle(1);
        game_active = 1'b1;
        cycle(1);
        chk("count_restart", {24'd0, pattern_count}, 1);
        cycle(3);

        // One-cycle deassertion still passes through IDLE
        game_active = 1'b0;
        cycle(1);
        chk("glitch_idle_valid", {31'd0, pattern_valid}, 0);
        game_active = 1'b1;
        cycle(2);

        // Randomized drops and restarts
        repeat (20) begin
            game_active = 1'b1;
            cycle($urandom_range(1, 45));
            game_active = 1'b0;
            cycle($urandom_range(1, 3));
        end

        // Asynchronous reset in the middle of a gap
        game_active = 1'b1;
        cycle(P + 9);
        chk("in_gap_before_reset", {31'd0, pattern_valid}, 0);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_count", {24'd0, pattern_count}, 0);
        chk("async_reset_lfsr", {16'd0, dut.lfsr_state}, {16'd0, SEED});
        check_all();
        cycle(2);
        reset = 1'b0;
        chk("lfsr_after_release", {16'd0, dut.lfsr_state}, {16'd0, SEED});
        cycle(P + 2);
        game_active = 1'b0;
        cycle(2);

        // Long rounds on the 255-pattern instance until 1000 patterns are issued
        ga_long = 1'b1;
        for (int c = 0; c < 20000 && npat < 1000; c++) begin
            @(negedge clock);
            check_all();
            if (lvalid && !last_lvalid) begin
                npat++;
                chk("long_a_onehot", {31'd0, $onehot(la)}, 1);
                chk("long_b_onehot", {31'd0, $onehot(lb)}, 1);
                if (in_round > 0) begin
                    chk("long_a_differs", {31'd0, la != prev_la}, 1);
                    chk("long_b_differs", {31'd0, lb != prev_lb}, 1);
                end
                in_round++;
                prev_la = la; prev_lb = lb;
            end
            if (ldone && !last_ldone)
                chk("long_count_at_done", {24'd0, lcount}, 255);
            last_lvalid = lvalid;
            last_ldone  = ldone;
            if (ldone) in_round = 0;
            ga_long = !ldone;
        end
        chk("long_pattern_total", npat, 1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
